// File: rtl/param_cpu_pkg.sv
// Opcode map shared by the core and anything that assembles programs for it.
package param_cpu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;  // A <= B
    localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;  // A <= Im
    localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;  // B <= A
    localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
    localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
    localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;  // B <= Im
    localparam logic [OP_W-1:0] OP_HLT    = 4'b1000;
    localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
    localparam logic [OP_W-1:0] OP_NOP_A  = 4'b1010;
    localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
    localparam logic [OP_W-1:0] OP_NOP_C  = 4'b1100;
    localparam logic [OP_W-1:0] OP_NOP_D  = 4'b1101;
    localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

endpackage

// File: rtl/param_cpu_reg.sv
// General-purpose register with load enable and asynchronous active-low clear.
module cpu_reg #(
    parameter int W = 4
) (
    input  logic         clk_cpu,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] dat_out
);

    // Load on enable, clear asynchronously on reset
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            dat_out <= '0;
        end else if (ld) begin
            dat_out <= d;
        end
    end

endmodule

// File: rtl/param_cpu.sv
// Tiny accumulator-style CPU: two data registers, one adder, carry flag,
// output port, relative-free jumps and a sticky halt.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [DATA_W+3:0] inst,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] in_port,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] out_port,
    output logic              carry,
    output logic              halted
);

    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] imm;
    logic              exec;

    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] alu_src;
    logic [DATA_W:0]   sum;

    logic              ld_a;
    logic              ld_b;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   pc_inc;
    logic [DATA_W-1:0] out_nxt;
    logic              carry_nxt;
    logic              halt_nxt;

    assign opcode = inst[DATA_W+3:DATA_W];
    assign imm    = inst[DATA_W-1:0];
    // A halted core ignores inst_valid entirely; only reset restarts it.
    assign exec   = inst_valid & ~halted;

    // Decode and ALU: the destination of ADD selects which register feeds the adder
    always_comb begin
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        a_nxt     = reg_a;
        b_nxt     = reg_b;
        pc_inc    = pc + 1'b1;
        pc_nxt    = pc_inc;
        out_nxt   = out_port;
        carry_nxt = 1'b0;
        halt_nxt  = halted;
        alu_src   = (opcode == OP_ADD_B) ? reg_b : reg_a;
        sum       = {1'b0, alu_src} + {1'b0, imm};

        case (opcode)
            OP_ADD_A: begin
                ld_a      = 1'b1;
                a_nxt     = sum[DATA_W-1:0];
                carry_nxt = sum[DATA_W];
            end
            OP_ADD_B: begin
                ld_b      = 1'b1;
                b_nxt     = sum[DATA_W-1:0];
                carry_nxt = sum[DATA_W];
            end
            OP_MOV_AI: begin
                ld_a  = 1'b1;
                a_nxt = imm;
            end
            OP_MOV_BI: begin
                ld_b  = 1'b1;
                b_nxt = imm;
            end
            OP_MOV_AB: begin
                ld_a  = 1'b1;
                a_nxt = reg_b;
            end
            OP_MOV_BA: begin
                ld_b  = 1'b1;
                b_nxt = reg_a;
            end
            OP_IN_A: begin
                ld_a  = 1'b1;
                a_nxt = in_port;
            end
            OP_IN_B: begin
                ld_b  = 1'b1;
                b_nxt = in_port;
            end
            OP_OUT_B: out_nxt = reg_b;
            OP_OUT_I: out_nxt = imm;
            OP_JMP:   pc_nxt  = imm[PC_W-1:0];
            // JNC looks at the carry left by the previous instruction
            OP_JNC:   pc_nxt  = carry ? pc_inc : imm[PC_W-1:0];
            OP_HLT: begin
                pc_nxt   = pc;
                halt_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Core state registers advance only on execute edges
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            out_port <= '0;
            carry    <= 1'b0;
            halted   <= 1'b0;
        end else if (exec) begin
            pc       <= pc_nxt;
            out_port <= out_nxt;
            carry    <= carry_nxt;
            halted   <= halt_nxt;
        end
    end

    cpu_reg #(.W(DATA_W)) register_file_a (
        .clk_cpu (clk_cpu),
        .rst_n   (reset),
        .ld      (exec & ld_a),
        .d       (a_nxt),
        .dat_out (reg_a)
    );

    cpu_reg #(.W(DATA_W)) register_file_b (
        .clk_cpu (clk_cpu),
        .rst_n   (reset),
        .ld      (exec & ld_b),
        .d       (b_nxt),
        .dat_out (reg_b)
    );

endmodule

// File: tb/tb_param_cpu.sv
// Directed bench for param_cpu: a 4-bit core and an 8-bit/6-bit-pc core
// driven with short hand-assembled programs.
module tb_param_cpu;
    import param_cpu_pkg::*;

    logic clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // 4-bit core
    logic        reset4;
    logic [7:0]  inst4;
    logic        valid4;
    logic [3:0]  in4;
    logic [3:0]  pc4;
    logic [3:0]  out4;
    logic        carry4;
    logic        halted4;

    // 8-bit core, 6-bit pc
    logic        reset8;
    logic [11:0] inst8;
    logic        valid8;
    logic [7:0]  in8;
    logic [5:0]  pc8;
    logic [7:0]  out8;
    logic        carry8;
    logic        halted8;

    int n_tests = 0;
    int n_fail  = 0;

    param_cpu #(.DATA_W(4), .PC_W(4)) dut4 (
        .clk_cpu    (clk_cpu),
        .reset      (reset4),
        .inst       (inst4),
        .inst_valid (valid4),
        .in_port    (in4),
        .pc         (pc4),
        .out_port   (out4),
        .carry      (carry4),
        .halted     (halted4)
    );

    param_cpu #(.DATA_W(8), .PC_W(6)) dut8 (
        .clk_cpu    (clk_cpu),
        .reset      (reset8),
        .inst       (inst8),
        .inst_valid (valid8),
        .in_port    (in8),
        .pc         (pc8),
        .out_port   (out8),
        .carry      (carry8),
        .halted     (halted8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction to the 4-bit core for one execute edge
    task automatic step4(input logic [3:0] op, input logic [3:0] im);
        inst4  = {op, im};
        valid4 = 1'b1;
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic step8(input logic [3:0] op, input logic [7:0] im);
        inst8  = {op, im};
        valid8 = 1'b1;
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic state4(input string tag, input logic [3:0] e_pc, input logic [3:0] e_a,
                          input logic [3:0] e_b, input logic e_c, input logic [3:0] e_out);
        chk({tag, ".pc"},    32'(pc4),                           32'(e_pc));
        chk({tag, ".a"},     32'(dut4.register_file_a.dat_out),  32'(e_a));
        chk({tag, ".b"},     32'(dut4.register_file_b.dat_out),  32'(e_b));
        chk({tag, ".carry"}, 32'(carry4),                        32'(e_c));
        chk({tag, ".out"},   32'(out4),                          32'(e_out));
    endtask

    initial begin
        reset4 = 1'b0; inst4 = '0; valid4 = 1'b0; in4 = '0;
        reset8 = 1'b0; inst8 = '0; valid8 = 1'b0; in8 = '0;

        // ---------- 4-bit core ----------
        @(posedge clk_cpu);
        #1;
        state4("rst", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
        chk("rst.halted", 32'(halted4), 32'd0);
        reset4 = 1'b1;

        step4(OP_MOV_AI, 4'd3);
        step4(OP_ADD_A, 4'd14);            // 3+14=17 -> 1, carry
        state4("add_ovf", 4'd2, 4'd1, 4'd0, 1'b1, 4'd0);
        step4(OP_JNC, 4'd0);               // carry set: fall through, carry cleared
        state4("jnc_nt", 4'd3, 4'd1, 4'd0, 1'b0, 4'd0);
        step4(OP_OUT_I, 4'd7);
        step4(OP_ADD_A, 4'd15);            // 1+15=16 -> 0, carry
        state4("pre_stall", 4'd5, 4'd0, 4'd0, 1'b1, 4'd7);

        // Stall with an ADD sitting on the bus
        inst4  = {OP_ADD_A, 4'd15};
        valid4 = 1'b0;
        repeat (3) @(posedge clk_cpu);
        #1;
        state4("stall", 4'd5, 4'd0, 4'd0, 1'b1, 4'd7);
        step4(OP_ADD_A, 4'd15);            // 0+15=15, no carry
        state4("resume", 4'd6, 4'd15, 4'd0, 1'b0, 4'd7);

        step4(OP_JNC, 4'd2);               // carry clear: taken
        chk("jnc_taken.pc", 32'(pc4), 32'd2);
        step4(OP_MOV_BA, 4'd0);            // B=15
        step4(OP_ADD_B, 4'd15);            // 15+15=30 -> 14, carry
        state4("add_b", 4'd4, 4'd15, 4'd14, 1'b1, 4'd7);
        step4(OP_MOV_AB, 4'd0);            // A=14, carry cleared
        state4("mov_ab", 4'd5, 4'd14, 4'd14, 1'b0, 4'd7);

        step4(OP_HLT, 4'd0);
        chk("hlt.halted", 32'(halted4), 32'd1);
        chk("hlt.pc", 32'(pc4), 32'd5);
        for (int i = 0; i < 10; i++) step4(OP_ADD_A, 4'd1);
        state4("halt_hold", 4'd5, 4'd14, 4'd14, 1'b0, 4'd7);
        chk("halt_hold.halted", 32'(halted4), 32'd1);

        // Asynchronous reset between edges while halted
        #2;
        reset4 = 1'b0;
        #1;
        state4("async_rst", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
        chk("async_rst.halted", 32'(halted4), 32'd0);
        @(posedge clk_cpu);
        #1;
        reset4 = 1'b1;

        // 16 NOPs wrap pc back to 0
        for (int i = 0; i < 16; i++) begin
            case (i % 3)
                0: step4(OP_NOP_A, 4'(i));
                1: step4(OP_NOP_C, 4'(i));
                default: step4(OP_NOP_D, 4'(i));
            endcase
        end
        chk("wrap.pc", 32'(pc4), 32'd0);
        step4(OP_JMP, 4'd9);
        chk("jmp.pc", 32'(pc4), 32'd9);
        in4 = 4'd6;
        step4(OP_IN_A, 4'd0);
        chk("in_a.a", 32'(dut4.register_file_a.dat_out), 32'd6);
        step4(OP_ADD_A, 4'd12);            // 6+12=18 -> 2, carry
        chk("add12.carry", 32'(carry4), 32'd1);
        step4(OP_NOP_C, 4'd0);             // NOP clears carry
        state4("nop_clr", 4'd12, 4'd2, 4'd0, 1'b0, 4'd0);
        in4 = 4'd9;
        step4(OP_IN_B, 4'd0);
        step4(OP_OUT_B, 4'd0);
        state4("in_out_b", 4'd14, 4'd2, 4'd9, 1'b0, 4'd9);
        valid4 = 1'b0;

        // ---------- 8-bit core ----------
        reset8 = 1'b1;
        step8(OP_MOV_BI, 8'hFF);
        step8(OP_ADD_B, 8'h01);            // 0xFF+1 -> 0x00, carry
        chk("w8_add.b", 32'(dut8.register_file_b.dat_out), 32'h00);
        chk("w8_add.carry", 32'(carry8), 32'd1);
        chk("w8_add.pc", 32'(pc8), 32'd2);
        step8(OP_OUT_B, 8'h00);
        chk("w8_outb.out", 32'(out8), 32'h00);
        chk("w8_outb.carry", 32'(carry8), 32'd0);
        step8(OP_OUT_I, 8'hA5);
        chk("w8_outi.out", 32'(out8), 32'hA5);
        chk("w8_outi.pc", 32'(pc8), 32'd4);
        step8(OP_JMP, 8'hFF);              // only low 6 bits reach pc
        chk("w8_jmp.pc", 32'(pc8), 32'd63);
        step8(OP_NOP_A, 8'h00);
        chk("w8_wrap.pc", 32'(pc8), 32'd0);
        step8(OP_MOV_AI, 8'hC8);
        step8(OP_ADD_A, 8'h37);            // 200+55=255, no carry
        chk("w8_add_a.a", 32'(dut8.register_file_a.dat_out), 32'hFF);
        chk("w8_add_a.carry", 32'(carry8), 32'd0);
        valid8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning width of registers A/B, immediate, in_port and out_port (legal 4..16).
REQ-002 SHALL have parameter PC_W, default 4, meaning program counter width (legal 2..DATA_W).
REQ-003 SHALL have port clk_cpu  input  1  single CPU clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inst  input  DATA_W+4  instruction word: opcode [DATA_W+3:DATA_W], immediate [DATA_W-1:0].
REQ-006 SHALL have port inst_valid  input  1  inst is valid this cycle; low stalls the core.
REQ-007 SHALL have port in_port  input  DATA_W  external input data, sampled by IN instructions.
REQ-008 SHALL have port pc  output  PC_W  address of the instruction currently presented on inst.
REQ-009 SHALL have port out_port  output  DATA_W  registered output port.
REQ-010 SHALL have port carry  output  1  carry flag.
REQ-011 SHALL have port halted  output  1  core stopped by HLT.

Function
REQ-012 SHALL execute one instruction per clk_cpu edge when inst_valid=1 and halted=0 ("execute edge").
REQ-013 SHALL, on any edge without execute, hold pc, A, B, carry, out_port and halted unchanged.
REQ-014 SHALL compute ALU result as a DATA_W+1-bit sum; low DATA_W bits go to the destination and bit DATA_W goes to carry.
REQ-015 SHALL decode opcodes: 0000 ADD A,Im (A<=A+Im); 0101 ADD B,Im (B<=B+Im); 0011 MOV A,Im; 0111 MOV B,Im; 0001 MOV A,B; 0100 MOV B,A.
REQ-016 SHALL decode opcodes: 0010 IN A (A<=in_port); 0110 IN B (B<=in_port); 1001 OUT B (out_port<=B); 1011 OUT Im (out_port<=Im).
REQ-017 SHALL decode opcodes: 1111 JMP Im (pc<=Im[PC_W-1:0]); 1110 JNC Im (jump only if carry==0 before the edge, else pc+1).
REQ-018 SHALL decode opcode 1000 HLT: set halted=1 and hold pc at the HLT address until reset.
REQ-019 SHALL treat opcodes 1010, 1100 and 1101 as NOP: pc+1, all other state unchanged except carry<=0.
REQ-020 SHALL update carry on every execute edge; only ADD can set it, and every other instruction (including JMP/JNC/OUT/NOP/HLT) clears it.
REQ-021 SHALL increment pc by 1 modulo 2^PC_W for every non-jump, non-HLT instruction (wrap from all-ones to 0).
REQ-022 SHALL wrap ADD results modulo 2^DATA_W, with carry=1 exactly when the true sum is >= 2^DATA_W.
REQ-023 SHALL, when reset asserts mid-stall or while halted, return to reset state immediately, regardless of inst_valid.

Reset
REQ-024 SHALL, while reset=0, force pc=0, A=0, B=0, carry=0, out_port=0 and halted=0 asynchronously.
REQ-025 SHALL begin execution at pc=0 on the first execute edge after reset deasserts.

Structure
REQ-026 SHALL define opcode constants in a shared package param_cpu_pkg.
REQ-027 SHALL implement A and B as two instances, register_file_a and register_file_b, of sub-module cpu_reg (DATA_W-wide, load enable, async active-low clear), each exposing dat_out.
REQ-028 SHALL keep decode and the ALU combinational, with the pc, carry, out_port and halted registers in param_cpu.

Verification
REQ-029 SHALL be verified with DATA_W=4: reset, then MOV A,3; ADD A,14 -> A=1, carry=1, pc=2; next JNC 0 -> pc=3, carry=0.
REQ-030 SHALL be verified with DATA_W=8, PC_W=6: MOV B,0xFF; ADD B,1 -> B=0x00, carry=1; OUT B -> out_port=0x00; OUT 0xA5 -> out_port=0xA5.
REQ-031 SHALL be verified with a stall: inst_valid=0 for 3 edges mid-program -> pc, A, B, carry and out_port unchanged; execution resumes identically when inst_valid returns to 1.
REQ-032 SHALL be verified with wrap and jump: 16 NOPs from pc=0 (PC_W=4) -> pc=0; JMP 9 -> pc=9; in_port=6, IN A -> A=6.
REQ-033 SHALL be verified with halt and reset: HLT at pc=5 -> halted=1, pc=5 held for 10 edges; reset=0 asynchronously between edges -> all outputs 0 before the next edge.
